// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier with valid/ready flow control.
// Operands and result are packed {sign, biased exponent, fraction}, with a hidden leading 1.
// The product is rounded to nearest even. Exponent overflow saturates the result and raises ovf.
// Exponent underflow flushes the result to signed zero and raises unf.
module fp_mult_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p,
    output logic         ovf,
    output logic         unf
);

    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;
    localparam logic signed [EW-1:0] L_EMAX = EW'(EMAX);
    localparam logic signed [EW-1:0] L_ONE  = EW'(1);

    // Stage load enables: a stage loads when it is empty or its successor loads.
    logic w_ld1, w_ld2, w_ld3;
    logic r1_valid, r2_valid, r3_valid;

    assign w_ld3    = !r3_valid || out_ready;
    assign w_ld2    = !r2_valid || w_ld3;
    assign w_ld1    = !r1_valid || w_ld2;
    assign in_ready = !rst && w_ld1;

    // ---------------- S1: unpack + multiply ----------------
    logic [EXP_W-1:0]     w_ea, w_eb;
    logic [MAN_W-1:0]     w_ma, w_mb;
    logic                 w_s1_zero;
    logic signed [EW-1:0] w_s1_exp;
    logic [PW-1:0]        w_s1_prod;

    assign w_ea      = a[W-2 -: EXP_W];
    assign w_eb      = b[W-2 -: EXP_W];
    assign w_ma      = a[MAN_W-1:0];
    assign w_mb      = b[MAN_W-1:0];
    assign w_s1_zero = (w_ea == '0) || (w_eb == '0);
    assign w_s1_exp  = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);
    assign w_s1_prod = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});

    logic                 r1_sign, r1_zero;
    logic signed [EW-1:0] r1_exp;
    logic [PW-1:0]        r1_prod;

    // S1 register: capture sign, zero flag, biased exponent sum and raw mantissa product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_zero  <= 1'b0;
            r1_exp   <= '0;
            r1_prod  <= '0;
        end else if (w_ld1) begin
            r1_valid <= in_valid;
            r1_sign  <= a[W-1] ^ b[W-1];
            r1_zero  <= w_s1_zero;
            r1_exp   <= w_s1_exp;
            r1_prod  <= w_s1_prod;
        end
    end

    // ---------------- S2: normalize + guard/round/sticky ----------------
    logic                 w_norm;
    logic [PW-1:0]        w_sh;
    logic signed [EW-1:0] w_s2_exp;

    // Left-align the product so the leading 1 is always the MSB; the dropped
    // low bits then split into G, R and a sticky OR independent of norm.
    assign w_norm   = r1_prod[PW-1];
    assign w_sh     = w_norm ? r1_prod : (r1_prod << 1);
    assign w_s2_exp = r1_exp + EW'(w_norm);

    logic                 r2_sign, r2_zero;
    logic signed [EW-1:0] r2_exp;
    logic [MAN_W:0]       r2_mant;
    logic                 r2_g, r2_r, r2_s;

    // S2 register: normalized mantissa with hidden bit, adjusted exponent, G/R/S bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_zero  <= 1'b0;
            r2_exp   <= '0;
            r2_mant  <= '0;
            r2_g     <= 1'b0;
            r2_r     <= 1'b0;
            r2_s     <= 1'b0;
        end else if (w_ld2) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_zero  <= r1_zero;
            r2_exp   <= w_s2_exp;
            r2_mant  <= w_sh[PW-1 -: MAN_W+1];
            r2_g     <= w_sh[MAN_W];
            r2_r     <= w_sh[MAN_W-1];
            r2_s     <= |w_sh[MAN_W-2:0];
        end
    end

    // ---------------- S3: round + pack ----------------
    logic                 w_inc, w_rcarry;
    logic [MAN_W+1:0]     w_rsum;
    logic [MAN_W-1:0]     w_frac;
    logic signed [EW-1:0] w_s3_exp;
    logic [W-1:0]         w_p;
    logic                 w_ovf, w_unf;

    assign w_inc    = r2_g && (r2_r || r2_s || r2_mant[0]);
    assign w_rsum   = {1'b0, r2_mant} + (MAN_W+2)'(w_inc);
    assign w_rcarry = w_rsum[MAN_W+1];
    assign w_frac   = w_rcarry ? '0 : w_rsum[MAN_W-1:0];
    assign w_s3_exp = r2_exp + EW'(w_rcarry);

    // Final packing with zero-operand, saturation and flush-to-zero handling.
    always_comb begin
        w_p   = {r2_sign, w_s3_exp[EXP_W-1:0], w_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r2_zero) begin
            w_p = {r2_sign, {(W-1){1'b0}}};
        end else if (w_s3_exp > L_EMAX) begin
            w_p   = {r2_sign, {(W-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (w_s3_exp < L_ONE) begin
            w_p   = {r2_sign, {(W-1){1'b0}}};
            w_unf = 1'b1;
        end
    end

    logic [W-1:0] r_p;
    logic         r_ovf, r_unf;

    // Output register: holds its contents while the result is offered but not accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r_p      <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (w_ld3) begin
            r3_valid <= r2_valid;
            r_p      <= w_p;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
        end
    end

    assign out_valid = r3_valid;
    assign p         = r_p;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: scoreboard bench for fp_mult_pipe with an arithmetic reference model.
module tb_fp_mult_pipe;

    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX  = 2 ** EXP_W - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p;
    logic         ovf, unf;

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p;
        logic         ovf;
        logic         unf;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    exp_t hd;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer product of the significands, then RNE by remainder vs. half.
    function automatic logic [W+1:0] ref_mul(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int ea, eb, ma, mb, prod, e, shift, q, rem, half;
        logic sgn;
        logic [W-1:0] r;
        sgn = xa[W-1] ^ xb[W-1];
        ea  = int'(xa[W-2 -: EXP_W]);
        eb  = int'(xb[W-2 -: EXP_W]);
        if (ea == 0 || eb == 0) begin
            r = '0;
            r[W-1] = sgn;
            return {r, 2'b00};
        end
        ma   = (1 << MAN_W) + int'(xa[MAN_W-1:0]);
        mb   = (1 << MAN_W) + int'(xb[MAN_W-1:0]);
        prod = ma * mb;
        e    = ea + eb - BIAS;
        if (prod >= (1 << (2 * MAN_W + 1))) begin
            e++;
            shift = MAN_W + 1;
        end else begin
            shift = MAN_W;
        end
        q    = prod >> shift;
        rem  = prod - (q << shift);
        half = 1 << (shift - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == (1 << (MAN_W + 1))) begin
            q = 1 << MAN_W;
            e++;
        end
        if (e > EMAX) begin
            r = '1;
            r[W-1] = sgn;
            return {r, 2'b10};
        end
        if (e < 1) begin
            r = '0;
            r[W-1] = sgn;
            return {r, 2'b01};
        end
        r = {sgn, e[EXP_W-1:0], q[MAN_W-1:0]};
        return {r, 2'b00};
    endfunction

    // Present one operand pair until accepted; record the expected result at acceptance.
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit lat);
        int waited = 0;
        bit done   = 0;
        exp_t x;
        logic [W+1:0] m;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                m     = ref_mul(xa, xb);
                x.p   = m[W+1:2];
                x.ovf = m[1];
                x.unf = m[0];
                x.acc = cyc;
                x.lat = lat;
                sb.push_back(x);
                acc_cnt++;
                done = 1;
            end else if (++waited > 200) begin
                n_chk++;
                n_err++;
                $display("FAIL in_ready_timeout a=%h b=%h", xa, xb);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every offered result against the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_output p=%h ovf=%b unf=%b required=none", p, ovf, unf);
            end else begin
                hd = sb[0];
                n_chk++;
                if (p !== hd.p || ovf !== hd.ovf || unf !== hd.unf) begin
                    n_err++;
                    $display("FAIL %s got p=%h ovf=%b unf=%b required p=%h ovf=%b unf=%b",
                             out_ready ? "result" : "held_result", p, ovf, unf, hd.p, hd.ovf, hd.unf);
                end
                if (out_ready) begin
                    if (hd.lat) begin
                        n_chk++;
                        if (cyc != hd.acc + 3) begin
                            n_err++;
                            $display("FAIL latency got=%0d required=3", cyc - hd.acc);
                        end
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rdone;
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || p !== '0 || ovf !== 1'b0 || unf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got v=%b p=%h ovf=%b unf=%b required 0 00 0 0", out_valid, p, ovf, unf);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_after_reset got=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;

        // Directed cases
        send(8'h30, 8'h30, 1);
        drain();
        send(8'h38, 8'h38, 0);
        send(8'hC0, 8'h38, 0);
        send(8'h31, 8'h38, 0);
        send(8'h7F, 8'h7F, 0);
        send(8'h10, 8'h10, 0);
        send(8'h80, 8'h38, 0);
        send(8'h05, 8'hB3, 0);
        send(8'hFF, 8'h01, 0);
        drain();

        // Back-to-back stream with a 5-cycle output stall
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 0);
            end
            begin
                int k = 0;
                while (acc_cnt < base + 3 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_full got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight
        send(8'h38, 8'h38, 0);
        send(8'h31, 8'h38, 0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flush got out_valid=%b required=0", out_valid);
        end
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send(8'hC0, 8'h38, 1);
        drain();

        // Randomized traffic with random output back-pressure
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(W'($urandom), W'($urandom), 0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
